// File: rtl/fasta_pkg.sv
// fasta_pkg: shared constants for the FASTA sequence packer.
//   - FSM state encodings (IDLE, PRIME, HEADER, SEQ, FLUSH, DONE)
//   - ASCII control characters recognised in the FASTA stream
//   - 2-bit nucleotide codes and the byte-to-code helper
package fasta_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRIME  = 3'd1;
    localparam logic [2:0] ST_HEADER = 3'd2;
    localparam logic [2:0] ST_SEQ    = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [7:0] CH_GT = 8'h3E;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [1:0] NUC_A = 2'b00;
    localparam logic [1:0] NUC_C = 2'b01;
    localparam logic [1:0] NUC_G = 2'b10;
    localparam logic [1:0] NUC_T = 2'b11;

    // Returns {invalid, code}; anything that is not a nucleotide letter
    // encodes as A and raises the invalid bit.
    function automatic logic [2:0] nuc_encode(input logic [7:0] ch);
        logic [2:0] r;
        case (ch)
            8'h41, 8'h61: r = {1'b0, NUC_A};
            8'h43, 8'h63: r = {1'b0, NUC_C};
            8'h47, 8'h67: r = {1'b0, NUC_G};
            8'h54, 8'h74: r = {1'b0, NUC_T};
            default:      r = {1'b1, NUC_A};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fasta_seq_packer_packer.sv
// fasta_word_packer: accumulates LANE_W-bit lanes into a word, LSB lane first.
//   clear   - drop any partial word
//   push    - insert lane_in at the next free lane
//   flush   - emit a partial word (unused lanes are zero), no-op when empty
//   word_o  - word to write, valid while emit_o is high
//   emit_o  - a complete (push into last lane) or flushed partial word is ready
//   empty_o - no lanes currently occupied
module fasta_word_packer #(
    parameter int LANE_W = 8,
    parameter int LANES  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      flush,
    input  logic [LANE_W-1:0]         lane_in,
    output logic [LANE_W*LANES-1:0]   word_o,
    output logic                      emit_o,
    output logic                      empty_o
);

    localparam int W     = LANE_W * LANES;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    logic [W-1:0]     word_q, word_d, ins_s;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Current word with lane_in dropped into the lane selected by idx_q.
    always_comb begin
        ins_s = word_q;
        for (int i = 0; i < LANES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                ins_s[i*LANE_W +: LANE_W] = lane_in;
            end else begin
                ins_s[i*LANE_W +: LANE_W] = word_q[i*LANE_W +: LANE_W];
            end
        end
    end

    // Next-state and emit logic; lanes are cleared after each emit so a
    // later partial word is naturally zero-padded.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        emit_o = 1'b0;
        word_o = word_q;
        if (clear) begin
            word_d = {W{1'b0}};
            idx_d  = IDX_ZERO;
        end else if (push) begin
            if (idx_q == IDX_LAST) begin
                emit_o = 1'b1;
                word_o = ins_s;
                word_d = {W{1'b0}};
                idx_d  = IDX_ZERO;
            end else begin
                word_d = ins_s;
                idx_d  = idx_q + IDX_W'(1'b1);
            end
        end else if (flush) begin
            emit_o = (idx_q != IDX_ZERO);
            word_o = word_q;
            word_d = {W{1'b0}};
            idx_d  = IDX_ZERO;
        end else begin
            word_d = word_q;
            idx_d  = idx_q;
        end
    end

    assign empty_o = (idx_q == IDX_ZERO);

    // Lane accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= {W{1'b0}};
            idx_q  <= IDX_ZERO;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/fasta_seq_packer.sv
// fasta_seq_packer: streams a FASTA file from an external ROM and writes the
// bases (ASCII or 2-bit packed) into an external RAM.
//   start/rom_len          - run request and number of ROM bytes to process
//   rom_addr/rom_data      - ROM byte interface, data one cycle after address
//   ram_addr/ram_data/ram_we - RAM word write port
//   busy/done              - run status, done is a one-cycle pulse
//   overflow/err_invalid   - sticky RAM-full and bad-nucleotide flags
//   seq_count/base_count   - saturating record and stored-base counters
module fasta_seq_packer #(
    parameter int ROM_ADDR_WIDTH = 15,
    parameter int RAM_ADDR_WIDTH = 15,
    parameter int RAM_DATA_WIDTH = 8,
    parameter int ENCODE         = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ROM_ADDR_WIDTH:0]   rom_len,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]                rom_data,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_DATA_WIDTH-1:0] ram_data,
    output logic                      ram_we,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      err_invalid,
    output logic [15:0]               seq_count,
    output logic [31:0]               base_count
);
    import fasta_pkg::*;

    localparam int   LANE_W = (ENCODE != 0) ? 2 : 8;
    localparam int   LANES  = RAM_DATA_WIDTH / LANE_W;
    localparam logic ENC_ON = (ENCODE != 0);

    logic [2:0]                state_q, state_d;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [ROM_ADDR_WIDTH:0]   cnt_q, cnt_d, len_q, len_d;
    logic                      line_start_q, line_start_d;
    logic [RAM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, ram_addr_q, ram_addr_d;
    logic                      addr_full_q, addr_full_d;
    logic [RAM_DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                      ram_we_q, ram_we_d, busy_q, busy_d, done_q, done_d;
    logic                      overflow_q, overflow_d, err_invalid_q, err_invalid_d;
    logic [15:0]               seq_count_q, seq_count_d;
    logic [31:0]               base_count_q, base_count_d;

    logic [2:0]                enc_s;
    logic [7:0]                lane_full_s;
    logic                      pk_clear_s, pk_push_s, pk_flush_s, pk_emit_s, pk_empty_s;
    logic [RAM_DATA_WIDTH-1:0] pk_word_s;

    assign enc_s       = nuc_encode(rom_data);
    assign lane_full_s = ENC_ON ? {6'b000000, enc_s[1:0]} : rom_data;

    fasta_word_packer #(
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (pk_clear_s),
        .push    (pk_push_s),
        .flush   (pk_flush_s),
        .lane_in (lane_full_s[LANE_W-1:0]),
        .word_o  (pk_word_s),
        .emit_o  (pk_emit_s),
        .empty_o (pk_empty_s)
    );

    // Main FSM: byte classification, counters and RAM write scheduling.
    always_comb begin
        state_d       = state_q;
        rom_addr_d    = rom_addr_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        line_start_d  = line_start_q;
        wr_ptr_d      = wr_ptr_q;
        addr_full_d   = addr_full_q;
        ram_addr_d    = ram_addr_q;
        ram_data_d    = ram_data_q;
        ram_we_d      = 1'b0;
        done_d        = 1'b0;
        overflow_d    = overflow_q;
        err_invalid_d = err_invalid_q;
        seq_count_d   = seq_count_q;
        base_count_d  = base_count_q;
        pk_clear_s    = 1'b0;
        pk_push_s     = 1'b0;
        pk_flush_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rom_addr_d    = {ROM_ADDR_WIDTH{1'b0}};
                    cnt_d         = {(ROM_ADDR_WIDTH+1){1'b0}};
                    len_d         = rom_len;
                    line_start_d  = 1'b1;
                    wr_ptr_d      = {RAM_ADDR_WIDTH{1'b0}};
                    addr_full_d   = 1'b0;
                    overflow_d    = 1'b0;
                    err_invalid_d = 1'b0;
                    seq_count_d   = 16'd0;
                    base_count_d  = 32'd0;
                    pk_clear_s    = 1'b1;
                    state_d       = (rom_len == {(ROM_ADDR_WIDTH+1){1'b0}}) ? ST_DONE : ST_PRIME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                // Byte 0 lands on rom_data next cycle; prefetch byte 1 now.
                rom_addr_d = rom_addr_q + ROM_ADDR_WIDTH'(1'b1);
                state_d    = ST_SEQ;
            end
            ST_HEADER, ST_SEQ: begin
                if (cnt_q == len_q) begin
                    state_d = ST_FLUSH;
                end else begin
                    cnt_d      = cnt_q + (ROM_ADDR_WIDTH+1)'(1'b1);
                    rom_addr_d = rom_addr_q + ROM_ADDR_WIDTH'(1'b1);
                    if (state_q == ST_HEADER) begin
                        if (rom_data == CH_LF) begin
                            line_start_d = 1'b1;
                            state_d      = ST_SEQ;
                        end else begin
                            state_d = ST_HEADER;
                        end
                    end else if ((rom_data == CH_GT) && line_start_q) begin
                        // Packed mode word-aligns every record.
                        pk_flush_s  = ENC_ON && !pk_empty_s;
                        seq_count_d = (&seq_count_q) ? seq_count_q : seq_count_q + 16'd1;
                        state_d     = ST_HEADER;
                    end else if (rom_data == CH_LF) begin
                        line_start_d = 1'b1;
                    end else if (rom_data == CH_CR) begin
                        line_start_d = line_start_q;
                    end else begin
                        line_start_d  = 1'b0;
                        pk_push_s     = 1'b1;
                        err_invalid_d = err_invalid_q | (ENC_ON & enc_s[2]);
                        base_count_d  = (&base_count_q) ? base_count_q : base_count_q + 32'd1;
                    end
                end
            end
            ST_FLUSH: begin
                pk_flush_s = !pk_empty_s;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Once the last RAM address is used, any further word aborts the run.
        if (pk_emit_s) begin
            if (addr_full_q) begin
                overflow_d = 1'b1;
                state_d    = ST_DONE;
            end else begin
                ram_we_d    = 1'b1;
                ram_addr_d  = wr_ptr_q;
                ram_data_d  = pk_word_s;
                wr_ptr_d    = wr_ptr_q + RAM_ADDR_WIDTH'(1'b1);
                addr_full_d = &wr_ptr_q;
            end
        end else begin
            ram_we_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rom_addr_q    <= {ROM_ADDR_WIDTH{1'b0}};
            cnt_q         <= {(ROM_ADDR_WIDTH+1){1'b0}};
            len_q         <= {(ROM_ADDR_WIDTH+1){1'b0}};
            line_start_q  <= 1'b0;
            wr_ptr_q      <= {RAM_ADDR_WIDTH{1'b0}};
            addr_full_q   <= 1'b0;
            ram_addr_q    <= {RAM_ADDR_WIDTH{1'b0}};
            ram_data_q    <= {RAM_DATA_WIDTH{1'b0}};
            ram_we_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            err_invalid_q <= 1'b0;
            seq_count_q   <= 16'd0;
            base_count_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            rom_addr_q    <= rom_addr_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            line_start_q  <= line_start_d;
            wr_ptr_q      <= wr_ptr_d;
            addr_full_q   <= addr_full_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_q    <= ram_data_d;
            ram_we_q      <= ram_we_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            overflow_q    <= overflow_d;
            err_invalid_q <= err_invalid_d;
            seq_count_q   <= seq_count_d;
            base_count_q  <= base_count_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data    = ram_data_q;
    assign ram_we      = ram_we_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign err_invalid = err_invalid_q;
    assign seq_count   = seq_count_q;
    assign base_count  = base_count_q;

endmodule

// File: tb/tb_fasta_seq_packer.sv
// Bench for fasta_seq_packer: three instances (ASCII, 2-bit packed, and ASCII
// with a 4-word RAM), a table of FASTA vectors, a write scoreboard, and hand
// sequences for empty runs and mid-run reset.
module tb_fasta_seq_packer;

    typedef struct {
        int          sel;
        int          len;
        logic [31:0] words;
        int          nw;
        int          seq;
        int          base;
        bit          chk_base;
        bit          err;
        bit          ovf;
        bit          restart;
    } vec_t;

    typedef struct {
        int          sel;
        logic [14:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start_v;
    logic [15:0] rom_len;
    logic [2:0]  we_v, busy_v, done_v, ovf_v, err_v;
    logic [14:0] rom_addr_a, rom_addr_b, rom_addr_c, ram_addr_a, ram_addr_b;
    logic [1:0]  ram_addr_c;
    logic [7:0]  rom_data_a, rom_data_b, rom_data_c, ram_data_a, ram_data_b, ram_data_c;
    logic [15:0] seq_a, seq_b, seq_c;
    logic [31:0] base_a, base_b, base_c;

    logic [7:0]  rom_mem [3][64];
    logic [14:0] obs_addr [3];
    logic [7:0]  obs_data [3];
    logic [15:0] obs_seq [3];
    logic [31:0] obs_base [3];

    vec_t  vecs [8];
    string roms [8];
    wr_t   sb [$];
    int    done_total [3];
    int    n_checks = 0;
    int    n_pass = 0;

    fasta_seq_packer #(.ENCODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .rom_len(rom_len),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .ram_addr(ram_addr_a),
        .ram_data(ram_data_a), .ram_we(we_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .overflow(ovf_v[0]), .err_invalid(err_v[0]), .seq_count(seq_a), .base_count(base_a));

    fasta_seq_packer #(.ENCODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .rom_len(rom_len),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .ram_addr(ram_addr_b),
        .ram_data(ram_data_b), .ram_we(we_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .overflow(ovf_v[1]), .err_invalid(err_v[1]), .seq_count(seq_b), .base_count(base_b));

    fasta_seq_packer #(.RAM_ADDR_WIDTH(2), .ENCODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .rom_len(rom_len),
        .rom_addr(rom_addr_c), .rom_data(rom_data_c), .ram_addr(ram_addr_c),
        .ram_data(ram_data_c), .ram_we(we_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .overflow(ovf_v[2]), .err_invalid(err_v[2]), .seq_count(seq_c), .base_count(base_c));

    // Synchronous ROM models: data one cycle after address.
    always @(posedge clk) begin
        rom_data_a <= rom_mem[0][rom_addr_a[5:0]];
        rom_data_b <= rom_mem[1][rom_addr_b[5:0]];
        rom_data_c <= rom_mem[2][rom_addr_c[5:0]];
    end

    always_comb begin
        obs_addr[0] = ram_addr_a;
        obs_addr[1] = ram_addr_b;
        obs_addr[2] = {13'd0, ram_addr_c};
        obs_data[0] = ram_data_a;
        obs_data[1] = ram_data_b;
        obs_data[2] = ram_data_c;
        obs_seq[0]  = seq_a;
        obs_seq[1]  = seq_b;
        obs_seq[2]  = seq_c;
        obs_base[0] = base_a;
        obs_base[1] = base_b;
        obs_base[2] = base_c;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Write scoreboard and done-pulse counter.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) done_total[i] <= done_total[i] + 1;
            if (we_v[i]) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_write: inst %0d addr 0x%0h data 0x%0h, none expected",
                             i, obs_addr[i], obs_data[i]);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_inst", 32'(i), 32'(e.sel));
                    check("wr_addr", {17'd0, obs_addr[i]}, {17'd0, e.addr});
                    check("wr_data", {24'd0, obs_data[i]}, {24'd0, e.data});
                end
            end
        end
    end

    task automatic start_vec(input int k);
        vec_t v;
        v = vecs[k];
        for (int j = 0; j < 64; j++) begin
            rom_mem[v.sel][j] = (j < roms[k].len()) ? roms[k][j] : 8'h00;
        end
        for (int i = 0; i < v.nw; i++) begin
            wr_t e;
            e.sel  = v.sel;
            e.addr = 15'(i);
            e.data = v.words[i*8 +: 8];
            sb.push_back(e);
        end
        @(posedge clk); #1;
        rom_len = 16'(v.len);
        start_v[v.sel] = 1'b1;
        @(posedge clk); #1;
        start_v = 3'b000;
    endtask

    task automatic finish_vec(input int k, input int d0);
        vec_t v;
        int   cyc;
        v = vecs[k];
        if (v.restart) begin
            repeat (4) @(posedge clk);
            #1;
            rom_len = 16'd0;
            start_v[v.sel] = 1'b1;
            @(posedge clk); #1;
            start_v = 3'b000;
        end
        cyc = 0;
        while (done_total[v.sel] == d0 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", 32'(done_total[v.sel] != d0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 32'(done_total[v.sel] - d0), 32'd1);
        check("busy_idle", {31'd0, busy_v[v.sel]}, 32'd0);
        check("seq_count", {16'd0, obs_seq[v.sel]}, 32'(v.seq));
        if (v.chk_base) check("base_count", obs_base[v.sel], 32'(v.base));
        check("err_invalid", {31'd0, err_v[v.sel]}, {31'd0, v.err});
        check("overflow", {31'd0, ovf_v[v.sel]}, {31'd0, v.ovf});
        check("writes_left", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_vec(input int k);
        int d0;
        d0 = done_total[vecs[k].sel];
        start_vec(k);
        finish_vec(k, d0);
    endtask

    initial begin
        int cyc;
        int d0;
        rst_n = 1'b0;
        start_v = 3'b000;
        rom_len = 16'd0;
        for (int i = 0; i < 3; i++) done_total[i] = 0;

        //            sel len words          nw seq base chk err ovf rst
        roms[0] = ">s1\nACGT\n";             vecs[0] = '{0,  9, 32'h54474341, 4, 1, 4, 1'b1, 1'b0, 1'b0, 1'b0};
        roms[1] = ">a\nACGTTG\n>b\nC\n";     vecs[1] = '{1, 15, 32'h00010BE4, 3, 2, 7, 1'b1, 1'b0, 1'b0, 1'b0};
        roms[2] = ">x\nACNT\n";              vecs[2] = '{1,  8, 32'h000000C4, 1, 1, 4, 1'b1, 1'b1, 1'b0, 1'b0};
        roms[3] = ">o\nABCDEF\n";            vecs[3] = '{2, 10, 32'h44434241, 4, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        roms[4] = ">q\r\nAB\r\nC\n";         vecs[4] = '{0, 10, 32'h00434241, 3, 1, 3, 1'b1, 1'b0, 1'b0, 1'b0};
        roms[5] = ">m\nGGGGT\n";             vecs[5] = '{1,  9, 32'h000003AA, 2, 1, 5, 1'b1, 1'b0, 1'b0, 1'b0};
        roms[6] = ">a\nAC\n>b\nG\n";         vecs[6] = '{0, 11, 32'h00474341, 3, 2, 3, 1'b1, 1'b0, 1'b0, 1'b1};
        roms[7] = ">a\nACGTTG\n";            vecs[7] = '{1,  5, 32'h00000004, 1, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0};

        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_flags", {27'd0, busy_v[i], done_v[i], we_v[i], ovf_v[i], err_v[i]}, 32'd0);
            check("rst_counts", obs_base[i] | {16'd0, obs_seq[i]}, 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            run_vec(k);
            if (vecs[k].sel == 2) check("ovf_last_addr", {17'd0, obs_addr[2]}, 32'd3);
        end

        // Empty run: straight to DONE, pulse two edges after start.
        d0 = done_total[0];
        @(posedge clk); #1;
        rom_len = 16'd0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v = 3'b000;
        check("len0_busy", {31'd0, busy_v[0]}, 32'd1);
        @(posedge clk); #1;
        check("len0_done", {31'd0, done_v[0]}, 32'd1);
        check("len0_seq", {16'd0, seq_a}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("len0_once", 32'(done_total[0] - d0), 32'd1);

        // Reset in the middle of a sequence line.
        start_vec(0);
        cyc = 0;
        while (base_a < 32'd2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("mid_seq_reached", 32'(base_a >= 32'd2), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_flags", {27'd0, busy_v[0], done_v[0], we_v[0], ovf_v[0], err_v[0]}, 32'd0);
        check("rst_mid_rom_addr", {17'd0, rom_addr_a}, 32'd0);
        check("rst_mid_ram", {9'd0, ram_addr_a, ram_data_a}, 32'd0);
        check("rst_mid_counts", base_a | {16'd0, seq_a}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_stays_idle", {31'd0, busy_v[0]}, 32'd0);
        run_vec(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fasta_seq_packer.md
FASTA_SEQ_PACKER -- requirements
Module: fasta_seq_packer

Interface
REQ-001 SHALL have parameter ROM_ADDR_WIDTH, default 15, ROM byte-address width.
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 15, RAM word-address width.
REQ-003 SHALL have parameter RAM_DATA_WIDTH, default 8, RAM word width; multiple of 8 when ENCODE=0, multiple of 2 when ENCODE=1.
REQ-004 SHALL have parameter ENCODE, default 0; 0 = ASCII pass-through, 1 = 2-bit nucleotide packing.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, single-cycle request, honoured only in IDLE.
REQ-008 SHALL have port rom_len, input, ROM_ADDR_WIDTH+1, number of ROM bytes to process; sampled on accepted start.
REQ-009 SHALL have port rom_addr, output, ROM_ADDR_WIDTH, ROM byte address.
REQ-010 SHALL have port rom_data, input, 8, ROM byte, valid one cycle after rom_addr.
REQ-011 SHALL have port ram_addr, output, RAM_ADDR_WIDTH, RAM word address.
REQ-012 SHALL have port ram_data, output, RAM_DATA_WIDTH, RAM write word.
REQ-013 SHALL have port ram_we, output, 1, RAM write strobe.
REQ-014 SHALL have ports busy (1), done (1-cycle pulse), overflow (1, sticky), err_invalid (1, sticky), as outputs.
REQ-015 SHALL have ports seq_count (16) and base_count (32), outputs, records and bases stored.

Function
REQ-016 States SHALL be IDLE, PRIME, HEADER, SEQ, FLUSH, DONE.
REQ-017 IDLE + start: clear counters/flags, rom_addr<=0, go PRIME; start while busy SHALL be ignored.
REQ-018 rom_len=0 SHALL go IDLE->DONE directly, no ram_we.
REQ-019 PRIME SHALL last one cycle covering ROM latency; thereafter one byte SHALL be consumed per cycle, rom_addr incrementing each cycle.
REQ-020 Byte '>' (0x3E) at line start SHALL enter HEADER and increment seq_count; HEADER SHALL discard bytes up to and including 0x0A, then enter SEQ.
REQ-021 In SEQ, 0x0A and 0x0D SHALL be discarded; every other byte SHALL be stored as one base and increment base_count.
REQ-022 ENCODE=0: byte stored verbatim in 8-bit lane; ENCODE=1: A/a=00, C/c=01, G/g=10, T/t=11; any other stored byte SHALL encode 00 and set err_invalid.
REQ-023 Lanes SHALL fill LSB first; a full word SHALL produce ram_we for exactly one cycle at the next ram_addr, ram_addr then incrementing.
REQ-024 On '>' after stored bases (ENCODE=1 only), a partial word SHALL be written zero-padded so each record starts word-aligned; ENCODE=0 SHALL not pad between records.
REQ-025 After rom_len bytes consumed, FLUSH SHALL write any partial word zero-padded (no write if empty), then DONE.
REQ-026 DONE SHALL assert done for one cycle, deassert busy, return to IDLE; counters and flags SHALL hold until next accepted start.
REQ-027 A write needed after the word at address 2^RAM_ADDR_WIDTH-1 was written SHALL be suppressed, set overflow, and go to DONE; ram_addr SHALL not wrap.
REQ-028 busy SHALL be high in every state except IDLE.
REQ-029 seq_count and base_count SHALL saturate at all-ones.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE and all outputs to 0, including mid-transfer; no partial word SHALL be written after release.
REQ-031 Operation SHALL resume only on a start after rst_n high.

Structure
REQ-032 State encoding, ASCII constants ('>', LF, CR) and nucleotide codes SHALL live in package fasta_pkg.
REQ-033 Lane packing and zero-pad SHALL be sub-module fasta_word_packer (char in, lane count parameter, word out, full/flush).
REQ-034 ROM and RAM SHALL remain external memories.

Verification
REQ-035 ENCODE=0, W=8, ROM ">s1\nACGT\n", rom_len=9 -> RAM[0..3]="ACGT", seq_count=1, base_count=4, one done pulse.
REQ-036 ENCODE=1, W=8, ROM ">a\nACGTTG\n>b\nC\n" -> RAM[0]=0xE4, RAM[1]=0x0B, RAM[2]=0x01, seq_count=2, base_count=7.
REQ-037 ENCODE=1, ROM ">x\nACNT\n" -> RAM[0]=0xC4, err_invalid=1.
REQ-038 RAM_ADDR_WIDTH=2, ENCODE=0, W=8, 6 bases -> RAM[0..3] written, overflow=1, done pulse, ram_we never asserted for a fifth word.
REQ-039 rst_n low for one cycle mid-SEQ -> all outputs 0 immediately, IDLE, no further ram_we; subsequent start re-runs cleanly.
REQ-040 rom_len=0 -> done within 2 cycles of start, no ram_we; start pulsed while busy -> ignored, results unchanged.
